// File: rtl/frogger_pkg.sv
// Shared types and helpers for the Frogger obstacle pipeline.
package frogger_pkg;

    localparam int unsigned GRID_COLS_DEF = 20;
    localparam int unsigned GRID_ROWS_DEF = 15;
    localparam int unsigned COL_W         = 5;
    localparam int unsigned ROW_W         = 4;
    localparam int unsigned LEVEL_W       = 7;

    // Per-lane configuration as written by the game controller.
    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic             dir;  // 1 = moves right
        logic             en;
    } lane_cfg_t;

    // Floors a signed raw period; negative raw values (high levels) land on the floor.
    function automatic longint clamp_period(longint raw, longint floor_val);
        return (raw < floor_val) ? floor_val : raw;
    endfunction

endpackage

// File: rtl/lane_mover.sv
// One lane: step-period counter, level-dependent period, position and config registers.
module lane_mover
    import frogger_pkg::*;
#(
    parameter int unsigned LANE        = 0,
    parameter int unsigned GRID_COLS   = GRID_COLS_DEF,
    parameter int unsigned PERIOD_W    = 24,
    parameter int unsigned BASE_PERIOD = 2500000,
    parameter int unsigned LANE_SKEW   = 100000,
    parameter int unsigned LEVEL_STEP  = 150000,
    parameter int unsigned MIN_PERIOD  = 400000
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    input  logic               i_Run,
    input  logic [LEVEL_W-1:0] i_Level,
    input  logic               i_Cfg_Wr,
    input  lane_cfg_t          i_Cfg,
    output logic [COL_W-1:0]   o_Pos,
    output logic [ROW_W-1:0]   o_Row,
    output logic               o_En
);

    localparam int unsigned CALC_W = PERIOD_W + 8;
    localparam logic signed [CALC_W-1:0] LANE_BASE =
        CALC_W'(BASE_PERIOD + LANE * LANE_SKEW);
    localparam lane_cfg_t CFG_RESET = '{
        row: ROW_W'(LANE + 1),
        dir: 1'(LANE % 2),
        en:  1'b1
    };

    logic signed [CALC_W-1:0] level_cost;
    logic signed [CALC_W-1:0] period_raw;
    logic [PERIOD_W-1:0]      period;
    logic [PERIOD_W-1:0]      period_m1;
    logic [COL_W-1:0]         pos_step;

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [COL_W-1:0]    pos_q, pos_d;
    lane_cfg_t           cfg_q, cfg_d;

    // Period follows i_Level combinationally so a level change takes effect mid-count.
    always_comb begin
        level_cost = $signed(CALC_W'(i_Level)) * $signed(CALC_W'(LEVEL_STEP));
        period_raw = LANE_BASE - level_cost;
        period     = PERIOD_W'(clamp_period(longint'(period_raw), longint'(MIN_PERIOD)));
        period_m1  = period - PERIOD_W'(1);
    end

    // Wrap-around step in the lane's direction of travel.
    always_comb begin
        pos_step = pos_q;
        if (cfg_q.dir) begin
            pos_step = (pos_q == COL_W'(GRID_COLS - 1)) ? '0 : pos_q + COL_W'(1);
        end else begin
            pos_step = (pos_q == '0) ? COL_W'(GRID_COLS - 1) : pos_q - COL_W'(1);
        end
    end

    // Config write beats a coincident terminal count; disabled or frozen lanes hold.
    always_comb begin
        cfg_d = cfg_q;
        cnt_d = cnt_q;
        pos_d = pos_q;
        if (i_Cfg_Wr) begin
            cfg_d = i_Cfg;
            cnt_d = '0;
        end else if (i_Run && cfg_q.en) begin
            // >= rather than == so a shortened period fires on the next clock
            if (cnt_q >= period_m1) begin
                cnt_d = '0;
                pos_d = pos_step;
            end else begin
                cnt_d = cnt_q + PERIOD_W'(1);
            end
        end
    end

    // Lane state registers.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cfg_q <= CFG_RESET;
            cnt_q <= '0;
            pos_q <= '0;
        end else begin
            cfg_q <= cfg_d;
            cnt_q <= cnt_d;
            pos_q <= pos_d;
        end
    end

    assign o_Pos = pos_q;
    assign o_Row = cfg_q.row;
    assign o_En  = cfg_q.en;

endmodule

// File: rtl/traffic_lane_engine.sv
// Obstacle engine: NUM_LANES lane movers, per-car column generation and
// registered query / collision detection.
module traffic_lane_engine
    import frogger_pkg::*;
#(
    parameter int unsigned GRID_COLS     = GRID_COLS_DEF,
    parameter int unsigned GRID_ROWS     = GRID_ROWS_DEF,
    parameter int unsigned NUM_LANES     = 8,
    parameter int unsigned CARS_PER_LANE = 2,
    parameter int unsigned PERIOD_W      = 24,
    parameter int unsigned BASE_PERIOD   = 2500000,
    parameter int unsigned LANE_SKEW     = 100000,
    parameter int unsigned LEVEL_STEP    = 150000,
    parameter int unsigned MIN_PERIOD    = 400000
) (
    input  logic                         i_Clk,
    input  logic                         i_Rst_L,
    input  logic                         i_Run,
    input  logic [LEVEL_W-1:0]           i_Level,
    input  logic                         i_Cfg_Wr,
    input  logic [$clog2(NUM_LANES)-1:0] i_Cfg_Lane,
    input  logic [ROW_W-1:0]             i_Cfg_Row,
    input  logic                         i_Cfg_Dir,
    input  logic                         i_Cfg_En,
    input  logic [COL_W-1:0]             i_Frog_Col,
    input  logic [ROW_W-1:0]             i_Frog_Row,
    input  logic [COL_W-1:0]             i_Query_Col,
    input  logic [ROW_W-1:0]             i_Query_Row,
    output logic                         o_Query_Hit,
    output logic                         o_Collided,
    output logic                         o_Hit_Pulse
);

    localparam int unsigned LANE_W  = $clog2(NUM_LANES);
    localparam int unsigned SPACING = GRID_COLS / CARS_PER_LANE;

    lane_cfg_t        cfg_in;
    logic [COL_W-1:0] lane_pos [NUM_LANES];
    logic [ROW_W-1:0] lane_row [NUM_LANES];
    logic             lane_en  [NUM_LANES];
    logic [COL_W-1:0] car_col  [NUM_LANES][CARS_PER_LANE];

    logic query_in_grid, frog_in_grid;
    logic query_hit_d, collided_d;
    logic query_hit_q, collided_q, hit_pulse_q;

    assign cfg_in = '{row: i_Cfg_Row, dir: i_Cfg_Dir, en: i_Cfg_En};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lane_mover #(
            .LANE        (g),
            .GRID_COLS   (GRID_COLS),
            .PERIOD_W    (PERIOD_W),
            .BASE_PERIOD (BASE_PERIOD),
            .LANE_SKEW   (LANE_SKEW),
            .LEVEL_STEP  (LEVEL_STEP),
            .MIN_PERIOD  (MIN_PERIOD)
        ) u_lane_mover (
            .i_Clk    (i_Clk),
            .i_Rst_L  (i_Rst_L),
            .i_Run    (i_Run),
            .i_Level  (i_Level),
            .i_Cfg_Wr (i_Cfg_Wr && (i_Cfg_Lane == LANE_W'(g))),
            .i_Cfg    (cfg_in),
            .o_Pos    (lane_pos[g]),
            .o_Row    (lane_row[g]),
            .o_En     (lane_en[g])
        );

        for (genvar k = 0; k < CARS_PER_LANE; k++) begin : g_car
            // pos < GRID_COLS and offset < GRID_COLS, so one conditional subtract wraps it
            logic [COL_W:0] col_sum;
            assign col_sum = {1'b0, lane_pos[g]} + (COL_W + 1)'(k * SPACING);
            assign car_col[g][k] = (32'(col_sum) >= GRID_COLS)
                                 ? COL_W'(col_sum - (COL_W + 1)'(GRID_COLS))
                                 : col_sum[COL_W-1:0];
        end
    end

    // OR-reduce every enabled car against the query tile and the frog tile.
    always_comb begin
        query_in_grid = (32'(i_Query_Col) < GRID_COLS) && (32'(i_Query_Row) < GRID_ROWS);
        frog_in_grid  = (32'(i_Frog_Col) < GRID_COLS) && (32'(i_Frog_Row) < GRID_ROWS);
        query_hit_d   = 1'b0;
        collided_d    = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int k = 0; k < CARS_PER_LANE; k++) begin
                if (lane_en[l] && (lane_row[l] == i_Query_Row) &&
                    (car_col[l][k] == i_Query_Col)) begin
                    query_hit_d = 1'b1;
                end
                if (lane_en[l] && (lane_row[l] == i_Frog_Row) &&
                    (car_col[l][k] == i_Frog_Col)) begin
                    collided_d = 1'b1;
                end
            end
        end
        query_hit_d = query_hit_d && query_in_grid;
        collided_d  = collided_d && frog_in_grid;
    end

    // Output registers; the pulse marks the 0->1 edge of the collision flag.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            query_hit_q <= 1'b0;
            collided_q  <= 1'b0;
            hit_pulse_q <= 1'b0;
        end else begin
            query_hit_q <= query_hit_d;
            collided_q  <= collided_d;
            hit_pulse_q <= collided_d && !collided_q;
        end
    end

    assign o_Query_Hit = query_hit_q;
    assign o_Collided  = collided_q;
    assign o_Hit_Pulse = hit_pulse_q;

endmodule

// File: tb/tb_traffic_lane_engine.sv
// Scoreboard bench for traffic_lane_engine against a tile-level lane model.
module tb_traffic_lane_engine;

    localparam int Cols  = 20;
    localparam int Rows  = 15;
    localparam int Lanes = 2;
    localparam int Cars  = 2;
    localparam int Base  = 10;
    localparam int Skew  = 0;
    localparam int Step  = 2;
    localparam int MinP  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [6:0] level = '0;
    logic       cfg_wr = 1'b0;
    logic [0:0] cfg_lane = '0;
    logic [3:0] cfg_row = '0;
    logic       cfg_dir = 1'b0;
    logic       cfg_en = 1'b0;
    logic [4:0] f_col = '0;
    logic [3:0] f_row = '0;
    logic [4:0] q_col = '0;
    logic [3:0] q_row = '0;
    logic       q_hit, coll, pulse;

    traffic_lane_engine #(
        .GRID_COLS     (Cols),
        .GRID_ROWS     (Rows),
        .NUM_LANES     (Lanes),
        .CARS_PER_LANE (Cars),
        .PERIOD_W      (24),
        .BASE_PERIOD   (Base),
        .LANE_SKEW     (Skew),
        .LEVEL_STEP    (Step),
        .MIN_PERIOD    (MinP)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_n),
        .i_Run       (run),
        .i_Level     (level),
        .i_Cfg_Wr    (cfg_wr),
        .i_Cfg_Lane  (cfg_lane),
        .i_Cfg_Row   (cfg_row),
        .i_Cfg_Dir   (cfg_dir),
        .i_Cfg_En    (cfg_en),
        .i_Frog_Col  (f_col),
        .i_Frog_Row  (f_row),
        .i_Query_Col (q_col),
        .i_Query_Row (q_row),
        .o_Query_Hit (q_hit),
        .o_Collided  (coll),
        .o_Hit_Pulse (pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit hit;
        bit coll;
        bit pulse;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad = 0;

    // Reference model: lane position, elapsed clocks, and config, as plain integers.
    int m_pos[Lanes];
    int m_cnt[Lanes];
    int m_row[Lanes];
    bit m_dir[Lanes];
    bit m_en[Lanes];
    bit m_coll;

    bit q_hold = 1'b0;
    bit f_hold = 1'b0;

    task automatic check(input string name, input logic act, input bit exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int period_of(input int lane, input int lvl);
        int p;
        p = Base + lane * Skew - lvl * Step;
        return (p < MinP) ? MinP : p;
    endfunction

    function automatic bit occupied(input int col, input int row);
        if (col >= Cols || row >= Rows) return 1'b0;
        for (int l = 0; l < Lanes; l++) begin
            for (int k = 0; k < Cars; k++) begin
                if (m_en[l] && m_row[l] == row && (m_pos[l] + k * (Cols / Cars)) % Cols == col)
                    return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int l = 0; l < Lanes; l++) begin
            m_pos[l] = 0;
            m_cnt[l] = 0;
            m_row[l] = l + 1;
            m_dir[l] = bit'(l % 2);
            m_en[l]  = 1'b1;
        end
        m_coll = 1'b0;
    endtask

    // Each clock: predict the registered outputs, then advance the lanes.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                model_reset();
                e = '{hit: 1'b0, coll: 1'b0, pulse: 1'b0};
            end else begin
                e.hit   = occupied(int'(q_col), int'(q_row));
                e.coll  = occupied(int'(f_col), int'(f_row));
                e.pulse = e.coll && !m_coll;
                m_coll  = e.coll;
                for (int l = 0; l < Lanes; l++) begin
                    if (cfg_wr && int'(cfg_lane) == l) begin
                        m_row[l] = int'(cfg_row);
                        m_dir[l] = cfg_dir;
                        m_en[l]  = cfg_en;
                        m_cnt[l] = 0;
                    end else if (run && m_en[l]) begin
                        if (m_cnt[l] + 1 >= period_of(l, int'(level))) begin
                            m_pos[l] = (m_pos[l] + (m_dir[l] ? 1 : Cols - 1)) % Cols;
                            m_cnt[l] = 0;
                        end else begin
                            m_cnt[l]++;
                        end
                    end
                end
            end
            sb.push_back(e);
        end
    end

    // Monitor: outputs are presented every clock; compare just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("query_hit", q_hit, e.hit);
                check("collided", coll, e.coll);
                check("hit_pulse", pulse, e.pulse);
            end
        end
    end

    // Random tile picks, biased half the time onto a live car position.
    task automatic rand_inputs();
        int l;
        if (!q_hold) begin
            if ($urandom_range(0, 1) == 0) begin
                l     = $urandom_range(0, Lanes - 1);
                q_row = 4'(m_row[l]);
                q_col = 5'((m_pos[l] + $urandom_range(0, Cars - 1) * (Cols / Cars)) % Cols);
            end else begin
                q_row = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                    : 4'($urandom_range(0, 3));
                q_col = 5'($urandom_range(0, 23));
            end
        end
        if (!f_hold) begin
            if ($urandom_range(0, 2) == 0) begin
                l     = $urandom_range(0, Lanes - 1);
                f_row = 4'(m_row[l]);
                f_col = 5'(m_pos[l]);
            end else begin
                f_row = 4'($urandom_range(0, 4));
                f_col = 5'($urandom_range(0, 23));
            end
        end
    endtask

    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cfg_wr = 1'b0;
            rand_inputs();
        end
    endtask

    task automatic cfg_write(input int lane, input int row, input bit dir, input bit en);
        @(negedge clk);
        rand_inputs();
        cfg_lane = 1'(lane);
        cfg_row  = 4'(row);
        cfg_dir  = dir;
        cfg_en   = en;
        cfg_wr   = 1'b1;
    endtask

    initial begin
        bit found;

        // Reset with the frog on lane 0 car 0 and the query on lane 1 car 1.
        q_hold = 1'b1; f_hold = 1'b1;
        q_col = 5'd10; q_row = 4'd2; f_col = 5'd0; f_row = 4'd1;
        run = 1'b1; level = 7'd0;
        repeat (3) @(negedge clk);
        check("reset_query_hit", q_hit, 1'b0);
        check("reset_collided", coll, 1'b0);
        check("reset_hit_pulse", pulse, 1'b0);
        rst_n = 1'b1;
        cycle(3);
        q_col = 5'd11;
        cycle(3);
        q_hold = 1'b0;

        // Frog parked at (0,1) until lane 0 car 1 wraps round onto it.
        cycle(130);
        f_hold = 1'b0;

        // Level 3 and level 7 both give the floor period.
        level = 7'd3;
        cycle(40);
        level = 7'd7;
        cycle(40);
        level = 7'd0;
        cycle(10);

        // Lane 1 disabled: invisible and frozen.
        cfg_write(1, 2, 1'b1, 1'b0);
        cycle(60);
        cfg_write(1, 2, 1'b1, 1'b1);

        // Config write landing on lane 1's terminal count must suppress the step.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            cfg_wr = 1'b0;
            if (m_en[1] && m_cnt[1] + 1 >= period_of(1, int'(level))) found = 1'b1;
            else rand_inputs();
        end
        if (!found) begin
            n_total++;
            n_bad++;
            $display("FAIL wait_terminal: got no terminal count expected one within 40 clocks");
        end else begin
            q_hold   = 1'b1;
            q_row    = 4'd2;
            q_col    = 5'((m_pos[1] + 1) % Cols);
            cfg_lane = 1'b1; cfg_row = 4'd2; cfg_dir = 1'b1; cfg_en = 1'b1;
            cfg_wr   = 1'b1;
            cycle(3);
            q_hold = 1'b0;
        end

        // Frozen play field.
        run = 1'b0;
        cycle(50);
        run = 1'b1;

        // Mixed random traffic.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                cfg_write($urandom_range(0, Lanes - 1), $urandom_range(0, 15),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
            end else begin
                cycle(1);
            end
            if ($urandom_range(0, 19) == 0) level = 7'($urandom_range(0, 10));
            run = ($urandom_range(0, 9) != 0);
        end

        // Mid-run reset while the frog sits on a car.
        cfg_write(0, 1, 1'b0, 1'b1);
        cfg_write(1, 2, 1'b1, 1'b1);
        run = 1'b0;
        cycle(1);
        f_hold = 1'b1;
        f_row  = 4'd1;
        f_col  = 5'(m_pos[0]);
        cycle(3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_query_hit", q_hit, 1'b0);
        check("async_rst_collided", coll, 1'b0);
        check("async_rst_hit_pulse", pulse, 1'b0);
        cycle(2);
        rst_n  = 1'b1;
        run    = 1'b1;
        level  = 7'd0;
        f_hold = 1'b0;
        cycle(40);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/traffic_lane_engine.md
# traffic_lane_engine

Parametrised obstacle engine for the Frogger video pipeline. It holds the positions of every car across a configurable number of lanes and advances each lane at its own level-dependent rate. It detects frog/car overlap and answers per-tile "is a car here" queries for the renderer. It replaces the hard-wired per-car instances and the per-car compare chain in the top level.

## Interface
Parameters:
- GRID_COLS, 20, playfield width in tiles
- GRID_ROWS, 15, playfield height in tiles
- NUM_LANES, 8, number of independently moving lanes
- CARS_PER_LANE, 2, cars per lane, evenly spaced
- PERIOD_W, 24, width of step-period counters
- BASE_PERIOD, 2500000, clocks per step at level 0, lane 0
- LANE_SKEW, 100000, extra clocks per step for each lane index
- LEVEL_STEP, 150000, clocks removed per level
- MIN_PERIOD, 400000, floor on step period

Ports:
- i_Clk  in  1  system clock
- i_Rst_L  in  1  asynchronous, active-low reset
- i_Run  in  1  1 = lanes advance; 0 = freeze (counters hold)
- i_Level  in  7  current game level
- i_Cfg_Wr  in  1  one-cycle lane configuration write strobe
- i_Cfg_Lane  in  $clog2(NUM_LANES)  lane being configured
- i_Cfg_Row  in  4  grid row for that lane
- i_Cfg_Dir  in  1  1 = moves right, 0 = moves left
- i_Cfg_En  in  1  lane enabled
- i_Frog_Col  in  5  frog tile column
- i_Frog_Row  in  4  frog tile row
- i_Query_Col  in  5  renderer tile column
- i_Query_Row  in  4  renderer tile row
- o_Query_Hit  out  1  car occupies queried tile
- o_Collided  out  1  frog currently overlaps a car
- o_Hit_Pulse  out  1  one-cycle pulse on o_Collided rising edge

## Operation
- Reset state per lane L: pos = 0, row = L+1, dir = L[0], en = 1, counter = 0. All outputs 0.
- Car k of lane L sits at column (pos + k*(GRID_COLS/CARS_PER_LANE)) mod GRID_COLS. The modulo is computed by conditional subtract, with no divider.
- Lane period = max(MIN_PERIOD, BASE_PERIOD + L*LANE_SKEW − i_Level*LEVEL_STEP). The subtraction is signed, PERIOD_W+8 bits wide, and saturates at MIN_PERIOD before truncation.
- When i_Run=1 and en=1, the counter increments each clock. When counter ≥ period−1, the counter clears and pos steps once.
- Right-moving lanes step pos from GRID_COLS−1 to 0. Left-moving lanes step from 0 to GRID_COLS−1.
- If i_Level changes mid-count and the counter already exceeds the new period, the lane steps on the next clock.
- When a lane is disabled, its counter holds, its cars are invisible to queries and collision, and its pos is retained.
- A config write updates row/dir/en and clears that lane's counter. If it coincides with a step in the same lane, the write wins and no step occurs that cycle.
- Rows ≥ GRID_ROWS are legal but unreachable. Out-of-grid query or frog coordinates return 0.
- Several cars on one tile count as one hit.

## Timing
- o_Query_Hit is registered, with 1-cycle latency from i_Query_Col/Row, so the renderer pipelines sync by one clock.
- o_Collided is registered and reflects the frog and car positions of the previous cycle.
- o_Hit_Pulse asserts in the same cycle o_Collided goes 0→1, for exactly one clock. It re-arms only after o_Collided returns to 0.
- A position step is visible on o_Query_Hit/o_Collided two clocks after the terminal count.
- Asserting i_Rst_L low mid-operation clears everything immediately. The first step after release occurs period clocks later.

## Structure
- Package frogger_pkg holds GRID_COLS/ROWS defaults, coordinate widths, the lane config struct {row, dir, en}, and a period-computation function.
- Sub-module lane_mover, instantiated NUM_LANES times, contains the counter, period, pos register and config register. It outputs pos, row and en.
- The top level generates car columns, the OR-reduced query/collision compares and the output registers.

## Test plan
Bench parameters: BASE_PERIOD=10, LANE_SKEW=0, LEVEL_STEP=2, MIN_PERIOD=4, NUM_LANES=2, CARS_PER_LANE=2, GRID_COLS=20.

- Release reset, i_Run=1, level 0: lane 0 (dir 0) pos goes 0→19 after 10 clocks, then 18 after 20 clocks. Lane 1 (dir 1) pos goes 0→1→2.
- Level 3, then level 7: period is 4 in both cases. At level 7 the period is clamped to 4, not −4.
- Query row 2, column 10 at reset: o_Query_Hit=1 one clock later (lane 1, car 1). Column 11 gives 0.
- Frog at (0,1) at reset: o_Collided=1 and o_Hit_Pulse=1 for one clock. The frog stays put: pulse does not repeat until lane 0 moves away and back.
- Config write to lane 1 with en=0: queries in row 2 return 0, collisions in row 2 are suppressed, and pos is frozen.
- Config write in the same cycle as a lane-1 terminal count: pos unchanged and counter at 0. Hold i_Run=0 for 50 clocks: no pos changes.
